// File: rtl/delay_prog.sv
// Programmable-depth delay line: circular buffer of DMAX words with a
// combinational read tap selected by dly, a clock enable and a fill-based valid.
module delay_prog #(
    parameter int unsigned     W    = 1,
    parameter int unsigned     DMAX = 32,
    parameter logic [W-1:0]    RVAL = '0,
    localparam int unsigned    DW   = $clog2(DMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i,
    input  logic          ce,
    input  logic [DW-1:0] dly,
    output logic [W-1:0]  o,
    output logic          o_vld,
    output logic          dly_err
);

    localparam int unsigned AW = (DMAX > 1) ? $clog2(DMAX) : 1;

    logic [W-1:0]  mem [DMAX];
    logic [AW-1:0] wp;
    logic [DW-1:0] fill;
    logic [DW-1:0] dly_eff;
    logic [DW:0]   rd_sum;
    logic [AW-1:0] rd_idx;

    // Tap index (wp - dly_eff) mod DMAX, computed as wp + DMAX - dly_eff with one
    // conditional subtraction so no negative intermediate is ever formed.
    always_comb begin
        dly_err = (dly > DW'(DMAX));
        dly_eff = dly_err ? DW'(DMAX) : dly;
        rd_sum  = (DW + 1)'(wp) + (DW + 1)'(DMAX) - (DW + 1)'(dly_eff);
        if (rd_sum >= (DW + 1)'(DMAX))
            rd_sum = rd_sum - (DW + 1)'(DMAX);
        rd_idx  = AW'(rd_sum);
        if (dly_eff == '0) begin
            o     = i;
            o_vld = 1'b1;
        end else begin
            o     = mem[rd_idx];
            o_vld = (fill >= dly_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DMAX; k++)
                mem[k] <= RVAL;
            wp   <= '0;
            fill <= '0;
        end else if (ce) begin
            mem[wp] <= i;
            wp      <= (wp == AW'(DMAX - 1)) ? '0 : wp + 1'b1;
            if (fill != DW'(DMAX))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: tb/tb_delay_prog.sv
// Self-checking bench for delay_prog: table vectors, directed corner sequences
// and a random run, all scored against a history-queue reference model.
module tb_delay_prog;

    localparam int unsigned W    = 8;
    localparam int unsigned DMAX = 32;
    localparam logic [7:0]  RV   = 8'hAA;
    localparam int unsigned DW   = $clog2(DMAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  i;
    logic          ce;
    logic [DW-1:0] dly;
    logic [W-1:0]  o;
    logic          o_vld;
    logic          dly_err;

    int total = 0;
    int bad   = 0;

    delay_prog #(.W(W), .DMAX(DMAX), .RVAL(RV)) dut (
        .clk(clk), .rst(rst), .i(i), .ce(ce), .dly(dly),
        .o(o), .o_vld(o_vld), .dly_err(dly_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic o_vld;
        logic err;
        logic [7:0] o;
    } exp_t;

    typedef struct {
        logic       r;
        logic       c;
        logic [7:0] d;
        logic [5:0] dl;
        logic [7:0] eo;
        logic       ev;
        logic       ee;
    } vec_t;

    logic [7:0] hist[$];
    exp_t       exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] din, input logic [DW-1:0] d);
        exp_t e;
        int   n;
        n     = (d > DMAX) ? DMAX : int'(d);
        e.err = (d > DMAX);
        if (n == 0) begin
            e.o     = din;
            e.o_vld = 1'b1;
        end else begin
            e.o     = (hist.size() >= n) ? hist[hist.size() - n] : RV;
            e.o_vld = (hist.size() >= n);
        end
        return e;
    endfunction

    task automatic compare(input exp_t e, input bit o_always);
        chk("o_vld", 32'(o_vld), 32'(e.o_vld));
        chk("dly_err", 32'(dly_err), 32'(e.err));
        if (o_always || e.o_vld)
            chk("o", 32'(o), 32'(e.o));
    endtask

    // Drive one cycle; the expected post-edge outputs are queued at drive time
    // and popped once the DUT has reacted to the edge.
    task automatic step(input logic r, input logic c, input logic [7:0] d,
                        input logic [DW-1:0] dl, input bit o_always = 1'b1);
        exp_t e;
        @(negedge clk);
        rst = r; ce = c; i = d; dly = dl;
        if (!r)
            hist.delete();
        else if (c) begin
            hist.push_back(d);
            if (hist.size() > DMAX) void'(hist.pop_front());
        end
        exp_q.push_back(model(d, dl));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            compare(e, o_always);
        end
    endtask

    // Change dly without a clock edge; the tap must move combinationally.
    task automatic comb_check(input logic [DW-1:0] dl);
        dly = dl;
        #1;
        compare(model(i, dl), 1'b1);
    endtask

    vec_t       tbl[17];
    logic [7:0] saved_o;

    initial begin
        rst = 1'b0; ce = 1'b0; i = '0; dly = '0;

        tbl[0]  = '{1'b0, 1'b1, 8'h55, 6'd3, 8'hAA, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h01, 6'd3, 8'hAA, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'h02, 6'd3, 8'hAA, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'h03, 6'd3, 8'h01, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h04, 6'd3, 8'h02, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h05, 6'd3, 8'h03, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'h06, 6'd3, 8'h04, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'h07, 6'd4, 8'h04, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h08, 6'd4, 8'h04, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h09, 6'd4, 8'h04, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h0A, 6'd4, 8'h05, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h0B, 6'd4, 8'h06, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h0C, 6'd4, 8'h06, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'h0D, 6'd4, 8'h07, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 8'h0E, 6'd4, 8'h0A, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 8'h0F, 6'd4, 8'h0B, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 8'h10, 6'd4, 8'h0D, 1'b1, 1'b0};

        // Reset state, including the dly=0 bypass right after reset
        step(1'b0, 1'b0, 8'h00, 6'd3);
        chk("rst_o", 32'(o), 32'(RV));
        chk("rst_vld", 32'(o_vld), 32'd0);
        i = 8'h3C;
        comb_check(6'd0);
        chk("rst_bypass_o", 32'(o), 32'h3C);

        // Fill latency at dly=3 and ce gating at dly=4
        for (int k = 0; k < 17; k++) begin
            step(tbl[k].r, tbl[k].c, tbl[k].d, tbl[k].dl);
            chk("tbl_o", 32'(o), 32'(tbl[k].eo));
            chk("tbl_vld", 32'(o_vld), 32'(tbl[k].ev));
            chk("tbl_err", 32'(dly_err), 32'(tbl[k].ee));
        end

        // Delay change mid-stream: decrease keeps valid, increase past fill drops it
        step(1'b0, 1'b0, 8'h00, 6'd3);
        for (int k = 0; k < 10; k++)
            step(1'b1, 1'b1, 8'(8'h10 + k), 6'd3);
        comb_check(6'd5);
        chk("dly5_o", 32'(o), 32'h15);
        chk("dly5_vld", 32'(o_vld), 32'd1);
        comb_check(6'd20);
        chk("dly20_vld", 32'(o_vld), 32'd0);
        for (int k = 10; k < 25; k++)
            step(1'b1, 1'b1, 8'(8'h10 + k), 6'd20);
        chk("dly20_o_late", 32'(o), 32'(8'h10 + 5));
        chk("dly20_vld_late", 32'(o_vld), 32'd1);

        // Full-depth tap across several pointer wraps, bypass and clamped dly
        step(1'b0, 1'b0, 8'h00, 6'd32);
        for (int k = 0; k < 100; k++)
            step(1'b1, 1'b1, 8'(k), 6'd32);
        chk("dly32_o", 32'(o), 32'd68);
        saved_o = o;
        i = 8'hC3;
        comb_check(6'd0);
        chk("dly0_o", 32'(o), 32'hC3);
        comb_check(6'd40);
        chk("dly40_err", 32'(dly_err), 32'd1);
        chk("dly40_same", 32'(o), 32'(saved_o));
        step(1'b1, 1'b1, 8'hC4, 6'd40);
        chk("dly40_step_o", 32'(o), 32'd69);

        // Mid-stream reset with ce high must not capture its input
        step(1'b0, 1'b0, 8'h00, 6'd3);
        for (int k = 0; k < 6; k++)
            step(1'b1, 1'b1, 8'(8'h40 + k), 6'd3);
        step(1'b0, 1'b1, 8'h55, 6'd3);
        chk("midrst_o", 32'(o), 32'(RV));
        chk("midrst_vld", 32'(o_vld), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 8'(8'h60 + k), 6'd3);
            chk("midrst_no55", 32'(o == 8'h55), 32'd0);
        end
        chk("midrst_resume", 32'(o), 32'h62);

        // Random stream against the reference model
        step(1'b0, 1'b0, 8'h00, 6'd0);
        for (int k = 0; k < 10000; k++)
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                 DW'($urandom_range(0, DMAX)), 1'b0);

        if (exp_q.size() != 0)
            chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/delay_prog.md
Name: delay_prog

Overview:
Next-generation delay element: a W-bit wide, clocked delay line with a run-time programmable depth of 0..DMAX samples. It generalises the fixed chain of single-stage delays into a circular buffer with a selectable read tap, a clock enable, and a fill-based validity flag. It sits on any data path that needs a matched or tunable latency, e.g. aligning a control strobe with a pipelined datapath.

Parameters:
W, 1, data width in bits
DMAX, 32, maximum delay in enabled cycles; buffer depth; must be >= 1
RVAL, 0, W-bit value loaded into every buffer word on reset
DW, $clog2(DMAX+1), width of dly port (derived localparam; not overridden)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-low (rst=0 at a rising clk edge => reset)
i  input  W  input sample
ce  input  1  clock enable; 1 = write i and advance the line this edge
dly  input  DW  requested delay in enabled cycles, 0..DMAX
o  output  W  delayed sample
o_vld  output  1  o holds a genuine sample written since reset
dly_err  output  1  dly > DMAX; combinational

Behaviour:
- State: mem[0..DMAX-1] (W bits each), write pointer wp (0..DMAX-1), fill counter fill (0..DMAX, saturating).
- Reset (rst=0 at edge): mem[*]=RVAL, wp=0, fill=0. Reset has priority over ce; no write occurs on a reset edge.
- Enabled edge (rst=1, ce=1): mem[wp]<=i; wp<=(wp==DMAX-1)?0:wp+1; fill<=min(fill+1,DMAX).
- ce=0: no state change; o, o_vld stable while dly and i are stable.
- dly_eff = (dly>DMAX) ? DMAX : dly; dly_err = (dly>DMAX). Purely combinational; no latching.
- dly_eff=0: bypass, o=i combinationally, o_vld=1.
- dly_eff>=1: o = mem[(wp - dly_eff) mod DMAX] via a combinational read. o therefore equals the value of i captured dly_eff enabled edges earlier. o_vld = (fill >= dly_eff).
- Latency: for dly_eff=N>=1, a sample written at enabled edge k appears on o after enabled edge k+N-1, i.e. N-1 further enabled edges. The same sample is visible for exactly one enabled period.
- Outputs just after reset: o=RVAL and o_vld=0 for any dly_eff>=1. o=i and o_vld=1 for dly_eff=0. dly_err follows dly.
- Delay change mid-stream: takes effect combinationally. No flush and no restart, because history is retained. o_vld is recomputed from fill.
  - Decreasing dly never drops o_vld.
  - Increasing dly beyond fill drops o_vld until fill catches up.
- Wrap-around: pointer arithmetic is modulo DMAX. dly_eff=DMAX reads mem[wp], the oldest entry, before it is overwritten on the next enabled edge.
- Fill saturates at DMAX and is never decremented except by reset.
- DMAX=1: wp is constant 0; the only legal taps are dly 0 and 1.

Test Plan:
1. W=8, DMAX=32, RVAL=8'hAA. Reset, then dly=3, ce=1, i=1,2,3,... one per cycle -> o=8'hAA with o_vld=0 after enabled edges 1-2; after edge 3, o=1 and o_vld=1; then o tracks i-3 every cycle.
2. Stream 10 samples at dly=3, then set dly=5 -> o immediately shows the sample 5 back and o_vld stays 1. Set dly=20 -> o_vld=0 until fill reaches 20, then 1 with o=i(t-20).
3. dly=4, ce pattern 1,0,0,1,1,0,1 with i incrementing every cycle -> o changes only after ce=1 edges; samples presented while ce=0 never appear on o.
4. dly=32, stream 100 samples (wraps wp three times) -> o(t)=i(t-32) with no glitch at wrap. dly=0 -> o=i in the same cycle, o_vld=1. dly=40 -> dly_err=1 and output identical to the dly=32 case.
5. Mid-stream, rst=0 for one edge while ce=1 and i=8'h55 -> next cycle fill=0, o=RVAL, o_vld=0 (dly=3). 8'h55 is never output; normal fill resumes when rst=1.
6. Random i, ce, and in-range dly for 10k cycles against a reference queue model -> o and o_vld match every cycle whenever o_vld=1, and o_vld matches (fill>=dly_eff) always.
